hack_control: RTL

Multi-cycle control sequencer for the Hack datapath. It accepts one 16-bit instruction per valid/ready handshake and decodes it into the six ALU control bits and register/memory write strobes. It reads the ALU `zr`/`ng` status back to resolve jumps, then drives the PC with either a load or an increment. It sits between instruction fetch and the ALU, A/D registers, data memory and PC.

---
 rtl/hack_control.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/hack_control.sv
// hack_control: multi-cycle control sequencer for the Hack datapath.
// Accepts one instruction per valid/ready handshake, walks it through
// IDLE -> DECODE -> (EXEC) -> WB and drives ALU controls, A/D/M write
// strobes and PC load/increment.
// Optional macro HACK_CTRL_FLAG_REG_EN: capture alu_zr/alu_ng at the
// EXEC->WB edge and resolve jumps from the captured copy instead of the
// live ALU status.
module hack_control (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        alu_zr,
  input  logic        alu_ng,
  input  logic        mem_ack,
  output logic        zx,
  output logic        nx,
  output logic        zy,
  output logic        ny,
  output logic        f,
  output logic        no,
  output logic        a_sel,
  output logic        a_from_instr,
  output logic        a_load,
  output logic        d_load,
  output logic        m_write,
  output logic        pc_load,
  output logic        pc_inc,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;

  logic isCInstr;
  logic wbFire;
  logic zrUsed;
  logic ngUsed;
  logic jumpTaken;

  assign isCInstr = ir_q[15];

  // An A-instruction always retires after a single WB cycle; a C-instruction
  // waits in WB only while it has an M write outstanding.
  assign wbFire = ~isCInstr | ~ir_q[3] | mem_ack;

`ifdef HACK_CTRL_FLAG_REG_EN
  logic zrFlag_q;
  logic ngFlag_q;

  // Snapshot the ALU status as the instruction leaves EXEC so WB is immune
  // to later changes on the ALU inputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      zrFlag_q <= 1'b0;
      ngFlag_q <= 1'b0;
    end else if (state_q == EXEC) begin
      zrFlag_q <= alu_zr;
      ngFlag_q <= alu_ng;
    end
  end

  assign zrUsed = zrFlag_q;
  assign ngUsed = ngFlag_q;
`else
  assign zrUsed = alu_zr;
  assign ngUsed = alu_ng;
`endif

  assign jumpTaken = (ir_q[2] & ngUsed) | (ir_q[1] & zrUsed) | (ir_q[0] & ~ngUsed & ~zrUsed);

  // Next-state and instruction-register capture; instr is only looked at on
  // the accept cycle in IDLE, so anything offered while busy is dropped.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = DECODE;
        end
      end
      DECODE:  state_d = isCInstr ? EXEC : WB;
      EXEC:    state_d = WB;
      WB:      if (wbFire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and instruction register; reset aborts whatever is in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Output decode from state and ir; everything is forced low while reset is
  // high so an aborted instruction can never emit a strobe.
  always_comb begin
    instr_ready  = 1'b0;
    zx           = 1'b0;
    nx           = 1'b0;
    zy           = 1'b0;
    ny           = 1'b0;
    f            = 1'b0;
    no           = 1'b0;
    a_sel        = 1'b0;
    a_from_instr = 1'b0;
    a_load       = 1'b0;
    d_load       = 1'b0;
    m_write      = 1'b0;
    pc_load      = 1'b0;
    pc_inc       = 1'b0;
    done         = 1'b0;
    if (!reset) begin
      if (state_q == IDLE) begin
        instr_ready = 1'b1;
      end
      if (isCInstr && (state_q != IDLE)) begin
        {zx, nx, zy, ny, f, no} = ir_q[11:6];
        a_sel = ir_q[12];
      end
      if (state_q == WB) begin
        if (isCInstr) begin
          m_write = ir_q[3];
          if (wbFire) begin
            a_load  = ir_q[5];
            d_load  = ir_q[4];
            pc_load = jumpTaken;
            pc_inc  = ~jumpTaken;
            done    = 1'b1;
          end
        end else begin
          a_from_instr = 1'b1;
          a_load       = 1'b1;
          pc_inc       = 1'b1;
          done         = 1'b1;
        end
      end
    end
  end

endmodule
